debug_io_hub: RTL and testbench
===============================

Name: debug_io_hub

Overview:
- Parametrised board-debug front end between raw pushbuttons/DIP switches/LEDs and the PCIe user logic.
- Synchronises and debounces every input bit, generates rise pulses, sticky press flags and a press counter.
- Drives LEDs from a registered 4-mode source select.
- Replaces direct wiring of raw switches into o_debug and direct driving of LEDs from it.

Parameters:
N_BTN, 5, number of pushbuttons (1..16)
N_DIP, 8, number of DIP switch bits (1..16)
N_LED, 8, number of LEDs (4..16)
DEB_CYCLES, 2500000, cycles an input must hold a new level before it is accepted (>=2)
HB_HALF, 125000000, heartbeat half-period in cycles (>=1)

Ports:
i_clk  in  1  user clock
i_rstn  in  1  asynchronous reset, active-low
i_btn  in  N_BTN  raw pushbuttons, asynchronous, 1 = pressed
i_dip  in  N_DIP  raw DIP switches, asynchronous
i_host_led  in  N_LED  host-written LED pattern
i_led_sel  in  2  LED source: 0 host, 1 inputs, 2 status, 3 counter
i_link_up  in  1  PCIe link-up status
i_user_rstn  in  1  PCIe user reset status
i_clr  in  N_BTN  write-1-to-clear for sticky flags, sampled every cycle
o_btn  out  N_BTN  debounced button levels
o_btn_rise  out  N_BTN  one-cycle pulse on debounced 0->1
o_btn_sticky  out  N_BTN  sticky press flags
o_dip  out  N_DIP  debounced DIP levels
o_press_cnt  out  8  total button presses, wraps
o_led  out  N_LED  registered LED drive
o_debug  out  N_BTN+N_DIP  {o_btn, o_dip}, o_btn in MSBs

Behaviour:
- Reset (i_rstn=0, asynchronous):
  - all outputs 0;
  - sync flops, stable levels, debounce counters, heartbeat and press counter cleared.
  - Debounced state restarts at 0, so a DIP bit held at 1 through reset appears DEB_CYCLES+2 cycles after release.
- Synchroniser: 2-flop per input bit; no logic between the flops.
- Debounce, per bit, independent:
  - synced != stable: counter increments.
  - synced == stable: counter clears.
  - Counter reaching DEB_CYCLES-1 while mismatched: stable takes synced on that edge and the counter clears.
  - A clean edge on a raw input is reflected on o_btn/o_dip DEB_CYCLES+2 cycles later (+1 for asynchronous sampling).
  - A glitch shorter than DEB_CYCLES cycles never propagates.
- o_btn_rise[k]:
  - high for exactly the one cycle after stable[k] goes 0->1, i.e. registered, aligned with o_btn[k] first reading 1;
  - never asserted on 1->0.
- Sticky:
  - o_btn_sticky[k] sets on o_btn_rise[k];
  - clears when i_clr[k]=1;
  - same-cycle rise and clear: set wins.
- Press counter:
  - o_press_cnt += popcount(o_btn_rise) each cycle;
  - modulo 256, so 255 plus 1 gives 0.
- Heartbeat: internal bit toggles every HB_HALF cycles; counter free-runs from reset.
- o_led is registered, updated one cycle after its sources or i_led_sel change:
  - sel 0: i_host_led.
  - sel 1: {o_btn, o_dip} right-aligned; zero-padded if narrower than N_LED, truncated to its low N_LED bits if wider.
  - sel 2:
    - bit N_LED-1 = heartbeat;
    - bit N_LED-2 = i_link_up;
    - bit N_LED-3 = i_user_rstn;
    - low N_LED-3 bits = o_btn_sticky, zero-padded/truncated.
  - sel 3: o_press_cnt, zero-padded/truncated to N_LED.
- o_debug is combinational from the debounced registers; no extra latency.

Test Plan:
- DEB_CYCLES=4, HB_HALF=8. Release reset, i_btn=0, i_dip=8'hA5 -> o_dip=8'hA5 and o_debug=13'h00A5 within 6-7 cycles; o_led=0 with sel 0 and i_host_led=0.
- Raw i_btn[2] pulse of 3 cycles -> o_btn, o_btn_rise, sticky and counter unchanged. Hold 10 cycles -> o_btn[2]=1 and o_btn_rise=5'b00100 for exactly 1 cycle; o_btn_sticky[2]=1; o_press_cnt=1.
- i_clr[2]=1 on the same cycle as a new o_btn_rise[2] -> sticky stays 1. i_clr[2]=1 alone next cycle -> sticky 0.
- Press buttons 0 and 4 simultaneously 256 times plus 1 extra single press, starting from count 0 -> o_press_cnt=1 (512+1 mod 256).
- sel=2, link_up=1, user_rstn=0, sticky=5'b00011 -> o_led=8'b?1000011, with bit 7 toggling every 8 cycles. Switch to sel=0 with host 8'h3C -> o_led=8'h3C one cycle later.
- Assert i_rstn=0 mid-debounce with o_press_cnt=7 -> all outputs 0 immediately; after release, a held button produces a fresh rise and o_press_cnt=1.

Source files
------------

// File: rtl/debug_io_hub.sv
// Board-debug front end: per-bit sync/debounce of buttons and DIP switches,
// rise pulses, sticky press flags, a press counter and a registered LED source mux.

module debug_io_deb #(
    parameter int DEB_CYCLES = 2500000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // s1 -> s2 is a bare two-flop synchroniser; debounce logic only sees s2.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            s1     <= i_raw;
            s2     <= s1;
            o_rise <= 1'b0;
            if (s2 != o_level) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    o_level <= s2;
                    o_rise  <= s2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module debug_io_hub #(
    parameter int N_BTN      = 5,
    parameter int N_DIP      = 8,
    parameter int N_LED      = 8,
    parameter int DEB_CYCLES = 2500000,
    parameter int HB_HALF    = 125000000
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [N_BTN-1:0]       i_btn,
    input  logic [N_DIP-1:0]       i_dip,
    input  logic [N_LED-1:0]       i_host_led,
    input  logic [1:0]             i_led_sel,
    input  logic                   i_link_up,
    input  logic                   i_user_rstn,
    input  logic [N_BTN-1:0]       i_clr,
    output logic [N_BTN-1:0]       o_btn,
    output logic [N_BTN-1:0]       o_btn_rise,
    output logic [N_BTN-1:0]       o_btn_sticky,
    output logic [N_DIP-1:0]       o_dip,
    output logic [7:0]             o_press_cnt,
    output logic [N_LED-1:0]       o_led,
    output logic [N_BTN+N_DIP-1:0] o_debug
);
    localparam int NDBG = N_BTN + N_DIP;
    localparam int NST  = N_LED - 3;
    localparam int HW   = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

    logic [NDBG-1:0] raw_all, lvl_all, rise_all;
    assign raw_all = {i_btn, i_dip};

    generate
        for (genvar g = 0; g < NDBG; g++) begin : g_deb
            debug_io_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .i_clk   (i_clk),
                .i_rstn  (i_rstn),
                .i_raw   (raw_all[g]),
                .o_level (lvl_all[g]),
                .o_rise  (rise_all[g])
            );
        end
    endgenerate

    assign o_btn      = lvl_all[NDBG-1:N_DIP];
    assign o_dip      = lvl_all[N_DIP-1:0];
    assign o_btn_rise = rise_all[NDBG-1:N_DIP];
    assign o_debug    = lvl_all;

    // DIP bits share the debounce cell but have no use for a rise pulse.
    logic unused_dip_rise;
    assign unused_dip_rise = ^rise_all[N_DIP-1:0];

    logic [7:0] rise_pop;
    always_comb begin
        rise_pop = '0;
        for (int k = 0; k < N_BTN; k++) rise_pop = rise_pop + 8'(o_btn_rise[k]);
    end

    logic [HW-1:0]    hb_cnt;
    logic             hb;
    logic [N_LED-1:0] led_nxt;

    always_comb begin
        led_nxt = i_host_led;
        unique case (i_led_sel)
            2'd0: led_nxt = i_host_led;
            2'd1: led_nxt = N_LED'(lvl_all);
            2'd2: led_nxt = {hb, i_link_up, i_user_rstn, NST'(o_btn_sticky)};
            default: led_nxt = N_LED'(o_press_cnt);
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_btn_sticky <= '0;
            o_press_cnt  <= '0;
            hb_cnt       <= '0;
            hb           <= 1'b0;
            o_led        <= '0;
        end else begin
            // A rise landing with its clear keeps the flag set.
            o_btn_sticky <= o_btn_rise | (o_btn_sticky & ~i_clr);
            o_press_cnt  <= o_press_cnt + rise_pop;
            if (hb_cnt == HW'(HB_HALF - 1)) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
            o_led <= led_nxt;
        end
    end
endmodule

// File: tb/tb_debug_io_hub.sv
// Scoreboarded bench for debug_io_hub with short debounce and heartbeat periods.

module tb_debug_io_hub;
    localparam int N_BTN = 5;
    localparam int N_DIP = 8;
    localparam int N_LED = 8;
    localparam int DEB   = 4;
    localparam int HB    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rstn;
    logic [N_BTN-1:0]       btn, clr;
    logic [N_DIP-1:0]       dip;
    logic [N_LED-1:0]       host;
    logic [1:0]             sel;
    logic                   link, urst;
    logic [N_BTN-1:0]       o_btn, o_btn_rise, o_btn_sticky;
    logic [N_DIP-1:0]       o_dip;
    logic [7:0]             o_press_cnt;
    logic [N_LED-1:0]       o_led;
    logic [N_BTN+N_DIP-1:0] o_debug;

    debug_io_hub #(
        .N_BTN(N_BTN), .N_DIP(N_DIP), .N_LED(N_LED), .DEB_CYCLES(DEB), .HB_HALF(HB)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_btn        (btn),
        .i_dip        (dip),
        .i_host_led   (host),
        .i_led_sel    (sel),
        .i_link_up    (link),
        .i_user_rstn  (urst),
        .i_clr        (clr),
        .o_btn        (o_btn),
        .o_btn_rise   (o_btn_rise),
        .o_btn_sticky (o_btn_sticky),
        .o_dip        (o_dip),
        .o_press_cnt  (o_press_cnt),
        .o_led        (o_led),
        .o_debug      (o_debug)
    );

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int cyc = 0;
    logic [N_BTN-1:0] rise_q[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_btn"},    32'(o_btn), 0);
        chk({tag, "_rise"},   32'(o_btn_rise), 0);
        chk({tag, "_sticky"}, 32'(o_btn_sticky), 0);
        chk({tag, "_dip"},    32'(o_dip), 0);
        chk({tag, "_cnt"},    32'(o_press_cnt), 0);
        chk({tag, "_led"},    32'(o_led), 0);
        chk({tag, "_debug"},  32'(o_debug), 0);
    endtask

    // Clean press and release; the rise pulse itself is checked by the monitor.
    task automatic press(input logic [N_BTN-1:0] m);
        rise_q.push_back(m);
        btn = m;
        tick(DEB + 2);
        chk("btn_lvl", 32'(o_btn), 32'(m));
        chk("debug", 32'(o_debug), 32'({m, 8'hA5}));
        tick(1);
        exp_cnt = (exp_cnt + $countones(m)) % 256;
        chk("cnt", 32'(o_press_cnt), 32'(exp_cnt));
        btn = '0;
        tick(DEB + 3);
    endtask

    always @(negedge clk) begin
        if (rstn && o_btn_rise != '0) begin
            if (rise_q.size() == 0) chk("rise_unexp", 32'(o_btn_rise), 0);
            else                    chk("rise", 32'(o_btn_rise), 32'(rise_q.pop_front()));
        end
    end

    initial begin
        logic [7:0] exp_led;
        rstn = 1'b0; btn = '0; dip = 8'hA5; host = '0; sel = 2'd0;
        link = 1'b0; urst = 1'b0; clr = '0;
        tick(2);
        chk_zero("rst");

        rstn = 1'b1;
        tick(DEB + 1);
        chk("dip_early", 32'(o_dip), 0);
        tick(1);
        chk("dip", 32'(o_dip), 32'h A5);
        chk("debug_dip", 32'(o_debug), 32'h00A5);
        chk("led_host0", 32'(o_led), 0);

        // Glitch one cycle shorter than the debounce window.
        btn = 5'b00100;
        tick(DEB - 1);
        btn = '0;
        tick(10);
        chk("glitch_btn", 32'(o_btn), 0);
        chk("glitch_sticky", 32'(o_btn_sticky), 0);
        chk("glitch_cnt", 32'(o_press_cnt), 0);

        press(5'b00100);
        chk("sticky_set", 32'(o_btn_sticky), 32'b00100);

        // Clear coinciding with a fresh rise, then clear alone.
        rise_q.push_back(5'b00100);
        btn = 5'b00100;
        tick(DEB + 2);
        clr = 5'b00100;
        tick(1);
        chk("sticky_setwins", 32'(o_btn_sticky), 32'b00100);
        tick(1);
        chk("sticky_clr", 32'(o_btn_sticky), 0);
        clr = '0;
        btn = '0;
        exp_cnt = exp_cnt + 1;
        chk("cnt2", 32'(o_press_cnt), 32'(exp_cnt));
        tick(DEB + 3);

        for (int i = 0; i < 256; i++) press(5'b10001);
        press(5'b00001);
        chk("cnt_wrap", 32'(o_press_cnt), 32'd3);

        clr = '1;
        tick(1);
        clr = '0;
        chk("sticky_all_clr", 32'(o_btn_sticky), 0);
        press(5'b00011);

        sel = 2'd2; link = 1'b1; urst = 1'b0;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            exp_led = 8'b0100_0011 | ((((cyc - 1) / HB) % 2 == 1) ? 8'h80 : 8'h00);
            chk("led_stat", 32'(o_led), 32'(exp_led));
            tick(1);
        end
        sel = 2'd0; host = 8'h3C;
        tick(1);
        chk("led_host", 32'(o_led), 32'h3C);
        sel = 2'd1;
        tick(1);
        chk("led_inputs", 32'(o_led), 32'hA5);
        sel = 2'd3;
        tick(1);
        chk("led_cnt", 32'(o_led), 32'd5);

        press(5'b00001);
        press(5'b00001);
        chk("cnt7", 32'(o_press_cnt), 32'd7);

        // Reset in the middle of a debounce.
        btn = 5'b00010;
        tick(3);
        rstn = 1'b0;
        #1;
        chk_zero("midrst");
        exp_cnt = 0;
        tick(2);
        rise_q.push_back(5'b00010);
        rstn = 1'b1;
        tick(DEB + 2);
        chk("post_rst_btn", 32'(o_btn), 32'b00010);
        tick(1);
        chk("post_rst_cnt", 32'(o_press_cnt), 32'd1);
        chk("post_rst_sticky", 32'(o_btn_sticky), 32'b00010);

        btn = '0;
        tick(DEB + 4);
        chk("rise_pending", 32'(rise_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
